// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

  localparam int DMEM_ADDR_W     = 16;
  localparam int DMEM_DATA_W     = 16;
  localparam int DMEM_ADDR_LIMIT = 511;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Load/store controller driving dmem with a one-cycle setup before a one-cycle chip select.
//
// state  | meaning
// IDLE   | ready for a request; out-of-range addresses go straight to RESP with error
// SETUP  | address/data/rw_ driven, CS low
// ACCESS | CS high; load data sampled at the closing edge
// RESP   | response held until rsp_ready
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int ADDR_LIMIT = DMEM_ADDR_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_rw_,
  output logic              dmem_cs,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [15:0]       access_cnt
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

  state_t    state;
  dmem_req_t req_in;
  logic      we_q;
  logic      addr_bad;

  assign req_in   = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign addr_bad = (req_in.addr >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      dmem_cs    <= 1'b0;
      dmem_rw_   <= RW_READ;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      access_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered high throughout IDLE, so req_valid alone completes the handshake
          if (req_valid) begin
            we_q      <= req_in.we;
            req_ready <= 1'b0;
            if (addr_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= SETUP;
              dmem_addr  <= req_in.addr;
              dmem_wdata <= req_in.wdata;
              dmem_rw_   <= req_in.we ? RW_WRITE : RW_READ;
            end
          end
        end
        SETUP: begin
          dmem_cs <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          dmem_cs    <= 1'b0;
          dmem_rw_   <= RW_READ;
          rsp_rdata  <= we_q ? '0 : dmem_rdata;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          access_cnt <= access_cnt + 16'd1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural 512-word dmem.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_rw_, dmem_cs;
  logic [15:0] access_cnt;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rw_(dmem_rw_), .dmem_cs(dmem_cs),
    .dmem_rdata(dmem_rdata), .access_cnt(access_cnt)
  );

  // dmem model, preloaded with addr ^ 0x1234
  logic [15:0] mem [0:511];
  initial for (int i = 0; i < 512; i++) mem[i] <= 16'(i) ^ 16'h1234;
  always @(posedge clk) if (dmem_cs && !dmem_rw_) mem[dmem_addr[8:0]] <= dmem_wdata;
  assign dmem_rdata = dmem_cs ? mem[dmem_addr[8:0]] : 16'hzzzz;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        sb[$];
  int          n_vec = 0, n_miss = 0;
  int          cyc = 0, cs_cycles = 0;
  logic        prev_cs = 1'b0, prev_rw = 1'b1;
  logic [15:0] prev_addr = 16'h0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int pending);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out, pending=%0d expected 0", name, pending);
  endtask

  always @(posedge clk) cyc++;

  // monitor: CS framing and response scoreboard, sampled just after the falling edge
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (dmem_cs) begin
      cs_cycles++;
      chk("cs_single_cycle", {31'b0, prev_cs}, 32'd0);
      if (!prev_cs) begin
        chk("cs_setup_addr", {16'b0, dmem_addr}, {16'b0, prev_addr});
        chk("cs_setup_rw", {31'b0, dmem_rw_}, {31'b0, prev_rw});
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got a response, expected none pending");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.rdata});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("access_cnt", {16'b0, access_cnt}, {16'b0, e.cnt});
      end
    end
    prev_cs   = dmem_cs;
    prev_addr = dmem_addr;
    prev_rw   = dmem_rw_;
  end

  task automatic push_exp(input logic [15:0] rdata, input logic err);
    exp_t e;
    if (!err) exp_cnt = exp_cnt + 16'd1;
    e.rdata = rdata;
    e.err   = err;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      timeout(name, sb.size());
      sb.delete();
    end
  endtask

  // called at a falling edge
  task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp_rdata, input logic exp_err);
    int t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) timeout("req_ready_wait", 1);
    push_exp(exp_rdata, exp_err);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain("rsp_wait");
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, {16'b0, rsp_rdata}, 32'd0);
    chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({tag, "_dmem_cs"}, {31'b0, dmem_cs}, 32'd0);
    chk({tag, "_dmem_rw_"}, {31'b0, dmem_rw_}, 32'd1);
    chk({tag, "_dmem_addr"}, {16'b0, dmem_addr}, 32'd0);
    chk({tag, "_dmem_wdata"}, {16'b0, dmem_wdata}, 32'd0);
    chk({tag, "_access_cnt"}, {16'b0, access_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    int   cs0, n, last;

    vt[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vt[2] = '{1'b1, 16'h01FE, 16'hA5A5, 16'h0000, 1'b0};
    vt[3] = '{1'b0, 16'h01FE, 16'h0000, 16'hA5A5, 1'b0};
    vt[4] = '{1'b0, 16'h01FF, 16'h0000, 16'h0000, 1'b1};
    vt[5] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b1};
    vt[6] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vt[7] = '{1'b0, 16'h0005, 16'h0000, 16'h1231, 1'b0};
    vt[8] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      cs0 = cs_cycles;
      send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
      chk($sformatf("vec%0d_cs_cycles", i), 32'(cs_cycles - cs0), vt[i].exp_err ? 32'd0 : 32'd1);
    end

    // response backpressure with an ignored request during the stall
    rsp_ready = 1'b0;
    push_exp(16'h0040 ^ 16'h1234, 1'b0);
    req_we    = 1'b0;
    req_addr  = 16'h0040;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("stall_rsp_valid", 1);
    cs0 = cs_cycles;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", {16'b0, rsp_rdata}, {16'b0, 16'h0040 ^ 16'h1234});
      chk("stall_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      if (k == 1) begin
        req_we    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'hDEAD;
        req_valid = 1'b1;
      end
      if (k == 2) req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    wait_drain("stall_drain");
    repeat (3) @(negedge clk);
    chk("stall_no_cs", 32'(cs_cycles - cs0), 32'd0);
    send(1'b0, 16'h0040, 16'h0, 16'h0040 ^ 16'h1234, 1'b0);

    // throughput: req_valid and rsp_ready held high
    n    = 0;
    last = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (req_ready) begin
        req_we    = 1'b0;
        req_addr  = 16'h0100 + 16'(n);
        req_valid = 1'b1;
        push_exp((16'h0100 + 16'(n)) ^ 16'h1234, 1'b0);
        if (n > 0) chk("tput_spacing", 32'(cyc - last), 32'd4);
        last = cyc;
        n++;
      end
    end
    chk("tput_accepts", 32'(n), 32'd8);
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain("tput_drain");

    // reset while a store sits in SETUP
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h1111;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("setup_cs_low", {31'b0, dmem_cs}, 32'd0);
    chk("setup_addr", {16'b0, dmem_addr}, 32'h0020);
    chk("setup_rw_write", {31'b0, dmem_rw_}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst     = 1'b0;
    exp_cnt = 16'h0;
    @(negedge clk);
    send(1'b0, 16'h0020, 16'h0, 16'h0020 ^ 16'h1234, 1'b0);

    // counter wrap via backdoor preload
    @(negedge clk);
    force dut.access_cnt = 16'hFFFF;
    #1;
    release dut.access_cnt;
    chk("cnt_preload", {16'b0, access_cnt}, 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    send(1'b0, 16'h0007, 16'h0, 16'h1233, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
